axi4_stream_pkt_gen: RTL and testbench
======================================

AXI4_STREAM_PKT_GEN -- requirements
Module: axi4_stream_pkt_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, tdata width in bits; multiple of 8.
REQ-002 SHALL have parameter ID_WIDTH, default 8, tid width.
REQ-003 SHALL have parameter DEST_WIDTH, default 4, tdest width.
REQ-004 SHALL have parameter USER_WIDTH, default 4, tuser width; at least 1.
REQ-005 SHALL have parameter GAP_CYCLES, default 0, idle cycles inserted between packets of one run.
REQ-006 SHALL have port aclk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port aresetn, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have port start_i, input, 1, one-cycle run request.
REQ-009 SHALL have port pkt_len_i, input, 16, packet length in bytes.
REQ-010 SHALL have port pkt_num_i, input, 16, number of packets per run.
REQ-011 SHALL have port tid_i, input, ID_WIDTH, tid for the run.
REQ-012 SHALL have port tdest_i, input, DEST_WIDTH, tdest for the run.
REQ-013 SHALL have port busy_o, output, 1, high while a run is active.
REQ-014 SHALL have port done_o, output, 1, one-cycle pulse at run end.
REQ-015 SHALL have port pkt_o, axi4_stream_if master modport with matching parameters, generated stream.

Function
REQ-016 SHALL implement states IDLE, SEND, GAP, DONE.
REQ-017 IDLE: start_i high SHALL latch pkt_len_i, pkt_num_i, tid_i and tdest_i, then go to SEND; latched values hold for the whole run.
REQ-018 start_i while not IDLE SHALL be ignored.
REQ-019 start_i with pkt_len_i=0 or pkt_num_i=0 SHALL go straight to DONE with no beats.
REQ-020 tvalid SHALL rise the cycle after start_i is sampled, i.e. 1-cycle latency.
REQ-021 Beats per packet SHALL equal ceil(len/(DATA_WIDTH/8)).
REQ-022 tlast SHALL be high only on the final beat of each packet.
REQ-023 tkeep SHALL be all-ones except on the last beat, where the low (len mod B) bits are set (all-ones if the remainder is 0); tstrb SHALL equal tkeep.
REQ-024 Byte k of packet p, counted from 0, SHALL be (k+p) mod 256 in little-endian lane order; bytes in unkept lanes SHALL be 0.
REQ-025 While tvalid is high and tready is low, tdata, tkeep, tstrb, tlast, tid, tdest and tuser SHALL hold stable.
REQ-026 tvalid SHALL NOT drop before the handshake completes.
REQ-027 A beat SHALL advance only on a cycle with tvalid and tready both high.
REQ-028 After the last beat of a packet that is not the final packet, the block SHALL enter GAP for GAP_CYCLES cycles with tvalid low, then return to SEND; with GAP_CYCLES=0 the next packet SHALL follow back-to-back with no bubble.
REQ-029 After the last beat of the final packet, the block SHALL enter DONE.
REQ-030 In DONE, done_o SHALL be high for one cycle, then the block SHALL return to IDLE.
REQ-031 busy_o SHALL be high in SEND, GAP and DONE.
REQ-032 Beat and packet counters SHALL be 16 bits with no wrap within a run; the maximum run is 65535 packets of 65535 bytes.

Reset
REQ-033 While aresetn is low, the block SHALL be in IDLE with tvalid, tlast, busy_o and done_o at 0 and tdata, tkeep, tstrb, tid, tdest and tuser at 0.
REQ-034 Reset asserted mid-run SHALL abort the run immediately with no done_o pulse.
REQ-035 After reset release, the first start_i SHALL be accepted no earlier than the cycle after aresetn rises.

Configuration
REQ-036 Macro AXI4_STREAM_PKT_GEN_SOF_EN defined: tuser[0] SHALL be 1 on the first beat of each packet and 0 on other beats; other tuser bits SHALL be 0.
REQ-037 Macro AXI4_STREAM_PKT_GEN_SOF_EN undefined: tuser SHALL be constant 0.

Verification
REQ-038 DATA_WIDTH=32, len=8, num=1, tready=1 -> 2 beats, tdata 0x03020100 then 0x07060504, tkeep 0xF and 0xF, tlast on beat 2, done_o 1 cycle later.
REQ-039 len=6, num=2, GAP_CYCLES=0, tready=1 -> beats 0x03020100/F, 0x00000504/3 with tlast, 0x04030201/F, 0x00000605/3 with tlast; no bubble between packets.
REQ-040 tready toggling 1-0-0-1, len=12 -> outputs stable across stalls, exactly 3 handshakes, byte order intact.
REQ-041 pkt_num=0 -> no tvalid, done_o pulses, busy_o high for exactly 1 cycle.
REQ-042 aresetn pulled low on the 2nd beat of a 4-beat packet -> tvalid 0 at once, no done_o; a new start afterwards begins again at byte 0.
REQ-043 SOF_EN defined, GAP_CYCLES=2, num=2 -> tuser[0]=1 on each first beat only, 2 idle cycles between packets.

Source files
------------

// File: rtl/axi4_stream_pkt_gen_if.sv
// AXI4-Stream interface bundle with master and slave views.
// Shared by the packet generator and whatever consumes its stream.
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 4
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tlast;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0]   tuser;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axi4_stream_pkt_gen.sv
// AXI4-Stream packet generator: runs of counting-pattern packets.
// Define AXI4_STREAM_PKT_GEN_SOF_EN to flag first beats on tuser[0].
module axi4_stream_pkt_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start_i,
    input  logic [15:0]           pkt_len_i,
    input  logic [15:0]           pkt_num_i,
    input  logic [ID_WIDTH-1:0]   tid_i,
    input  logic [DEST_WIDTH-1:0] tdest_i,
    output logic                  busy_o,
    output logic                  done_o,
    axi4_stream_if.master         pkt_o
);
    localparam int B = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t                state_q, state_d;
    logic [15:0]           nbeats_q, rem_q, num_q;
    logic [15:0]           beat_q, pkt_q;
    logic [31:0]           gap_q;
    logic [ID_WIDTH-1:0]   tid_q;
    logic [DEST_WIDTH-1:0] tdest_q;
    logic                  send, hs, last_beat, last_pkt;
    logic [7:0]            base;
    logic [DATA_WIDTH-1:0] data;
    logic [B-1:0]          keep;

    assign send      = (state_q == SEND);
    assign hs        = send & pkt_o.tready;
    assign last_beat = (beat_q == nbeats_q - 16'd1);
    assign last_pkt  = (pkt_q == num_q - 16'd1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            nbeats_q <= '0;
            rem_q    <= '0;
            num_q    <= '0;
            beat_q   <= '0;
            pkt_q    <= '0;
            gap_q    <= '0;
            tid_q    <= '0;
            tdest_q  <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: if (start_i) begin
                    nbeats_q <= 16'((32'(pkt_len_i) + 32'(B - 1)) / 32'(B));
                    rem_q    <= 16'(32'(pkt_len_i) % 32'(B));
                    num_q    <= pkt_num_i;
                    tid_q    <= tid_i;
                    tdest_q  <= tdest_i;
                    beat_q   <= '0;
                    pkt_q    <= '0;
                end
                SEND: if (hs) begin
                    if (last_beat) begin
                        beat_q <= '0;
                        pkt_q  <= pkt_q + 16'd1;
                        gap_q  <= '0;
                    end else begin
                        beat_q <= beat_q + 16'd1;
                    end
                end
                GAP:  gap_q <= gap_q + 32'd1;
                DONE: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        busy_o  = (state_q != IDLE);
        done_o  = (state_q == DONE);
        unique case (state_q)
            IDLE: if (start_i) begin
                if (pkt_len_i == 16'd0 || pkt_num_i == 16'd0)
                    state_d = DONE;
                else
                    state_d = SEND;
            end
            SEND: if (hs && last_beat) begin
                if (last_pkt)
                    state_d = DONE;
                else if (GAP_CYCLES == 0)
                    state_d = SEND;
                else
                    state_d = GAP;
            end
            GAP:  if (gap_q == 32'(GAP_CYCLES - 1)) state_d = SEND;
            DONE: state_d = IDLE;
        endcase
    end

    // Lane j of beat b carries byte (b*B + j + pkt) mod 256.
    always_comb begin
        data = '0;
        keep = '0;
        base = 8'(32'(beat_q) * 32'(B) + 32'(pkt_q));
        for (int j = 0; j < B; j++) begin
            if (send && !(last_beat && rem_q != 16'd0
                          && 32'(j) >= 32'(rem_q))) begin
                keep[j]        = 1'b1;
                data[8*j +: 8] = base + 8'(j);
            end
        end
    end

    always_comb begin
        pkt_o.tvalid = send;
        pkt_o.tlast  = send & last_beat;
        pkt_o.tdata  = data;
        pkt_o.tkeep  = keep;
        pkt_o.tstrb  = keep;
        pkt_o.tid    = send ? tid_q : '0;
        pkt_o.tdest  = send ? tdest_q : '0;
        pkt_o.tuser  = '0;
`ifdef AXI4_STREAM_PKT_GEN_SOF_EN
        pkt_o.tuser[0] = send & (beat_q == 16'd0);
`endif
    end
endmodule

// File: tb/tb_axi4_stream_pkt_gen.sv
// Bench for axi4_stream_pkt_gen: two instances (gap 0 and gap 2)
// checked every cycle against a byte-level packet model.
module tb_axi4_stream_pkt_gen;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [3:0]  user;
        logic        fin;
        logic [7:0]  tid;
        logic [3:0]  tdest;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] len, num;
    logic [7:0]  tid;
    logic [3:0]  tdest;

    logic        tv[2], tr[2], tl[2], bz[2], dn[2];
    logic [31:0] td[2];
    logic [3:0]  tk[2], ts[2], tu[2], tds[2];
    logic [7:0]  ti[2];

    beat_t q[3][$];
    logic  act[2], dexp[2], ingap[2];
    int    gapcnt[2];
    int    compared = 0;
    int    mismatched = 0;
    int    rmode = 0;
    int    pc = 0;
    logic [3:0] pbits = 4'b1001;

    always #5 clk = ~clk;

    axi4_stream_if #(.DATA_WIDTH(32), .ID_WIDTH(8),
                     .DEST_WIDTH(4), .USER_WIDTH(4)) if0 ();
    axi4_stream_if #(.DATA_WIDTH(32), .ID_WIDTH(8),
                     .DEST_WIDTH(4), .USER_WIDTH(4)) if1 ();

    axi4_stream_pkt_gen #(.DATA_WIDTH(32), .ID_WIDTH(8), .DEST_WIDTH(4),
                          .USER_WIDTH(4), .GAP_CYCLES(0)) dut0 (
        .aclk(clk), .aresetn(rst_n), .start_i(start),
        .pkt_len_i(len), .pkt_num_i(num), .tid_i(tid), .tdest_i(tdest),
        .busy_o(bz[0]), .done_o(dn[0]), .pkt_o(if0.master));

    axi4_stream_pkt_gen #(.DATA_WIDTH(32), .ID_WIDTH(8), .DEST_WIDTH(4),
                          .USER_WIDTH(4), .GAP_CYCLES(2)) dut1 (
        .aclk(clk), .aresetn(rst_n), .start_i(start),
        .pkt_len_i(len), .pkt_num_i(num), .tid_i(tid), .tdest_i(tdest),
        .busy_o(bz[1]), .done_o(dn[1]), .pkt_o(if1.master));

    assign if0.tready = tr[0];
    assign if1.tready = tr[1];
    assign tv[0] = if0.tvalid;  assign tv[1] = if1.tvalid;
    assign tl[0] = if0.tlast;   assign tl[1] = if1.tlast;
    assign td[0] = if0.tdata;   assign td[1] = if1.tdata;
    assign tk[0] = if0.tkeep;   assign tk[1] = if1.tkeep;
    assign ts[0] = if0.tstrb;   assign ts[1] = if1.tstrb;
    assign tu[0] = if0.tuser;   assign tu[1] = if1.tuser;
    assign ti[0] = if0.tid;     assign ti[1] = if1.tid;
    assign tds[0] = if0.tdest;  assign tds[1] = if1.tdest;

    function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endfunction

    // Expected beats, built byte by byte: byte k of packet p is (k+p)%256.
    function automatic void gen(int d, int l, int n,
                                logic [7:0] id, logic [3:0] de);
        int nb;
        nb = (l + 3) / 4;
        for (int p = 0; p < n; p++) begin
            for (int b = 0; b < nb; b++) begin
                beat_t t;
                t = '0;
                for (int j = 0; j < 4; j++) begin
                    int k;
                    k = b * 4 + j;
                    if (k < l) begin
                        t.data[8*j +: 8] = 8'((k + p) % 256);
                        t.keep[j] = 1'b1;
                    end
                end
                t.last = (b == nb - 1);
`ifdef AXI4_STREAM_PKT_GEN_SOF_EN
                t.user = (b == 0) ? 4'd1 : 4'd0;
`endif
                t.fin = (p == n - 1);
                t.tid = id;
                t.tdest = de;
                q[d].push_back(t);
            end
        end
    endfunction

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            case (rmode)
                0: tr[d] = 1'b1;
                1: tr[d] = 1'($urandom_range(0, 1));
                default: tr[d] = pbits[3 - (pc % 4)];
            endcase
        end
        pc++;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            beat_t e;
            logic nact, ndone;
            if (!rst_n) begin
                chk($sformatf("reset_out%0d", d),
                    {tv[d], tl[d], bz[d], dn[d], td[d], tk[d], ts[d],
                     ti[d], tds[d], tu[d]}, 64'd0);
                q[d].delete();
                act[d] = 1'b0;
                dexp[d] = 1'b0;
                ingap[d] = 1'b0;
            end else begin
                chk($sformatf("busy%0d", d), 64'(bz[d]), 64'(act[d]));
                chk($sformatf("done%0d", d), 64'(dn[d]), 64'(dexp[d]));
                nact = act[d];
                ndone = 1'b0;
                if (dexp[d]) nact = 1'b0;
                if (ingap[d]) begin
                    if (tv[d]) begin
                        chk($sformatf("gap%0d", d), 64'(gapcnt[d]),
                            (d == 0) ? 64'd0 : 64'd2);
                        ingap[d] = 1'b0;
                    end else begin
                        gapcnt[d]++;
                    end
                end
                if (tv[d]) begin
                    if (q[d].size() == 0) begin
                        chk($sformatf("extra_beat%0d", d), 64'(tv[d]), 64'd0);
                    end else begin
                        e = q[d][0];
                        chk($sformatf("beat%0d", d),
                            {td[d], tk[d], ts[d], tl[d], tu[d], ti[d], tds[d]},
                            {e.data, e.keep, e.keep, e.last, e.user,
                             e.tid, e.tdest});
                        if (tr[d]) begin
                            void'(q[d].pop_front());
                            if (e.last && e.fin) ndone = 1'b1;
                            else if (e.last) begin
                                ingap[d] = 1'b1;
                                gapcnt[d] = 0;
                            end
                        end
                    end
                end
                if (start && !act[d]) begin
                    nact = 1'b1;
                    if (len == 16'd0 || num == 16'd0) ndone = 1'b1;
                    else gen(d, int'(len), int'(num), tid, tdest);
                end
                act[d] = nact;
                dexp[d] = ndone;
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(posedge clk);
            if (!act[0] && !act[1] && q[0].size() == 0 && q[1].size() == 0)
                ok = 1'b1;
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL timeout: got busy expected idle");
        end
    endtask

    task automatic run(int l, int n, bit stray);
        @(posedge clk);
        #1;
        len = 16'(l);
        num = 16'(n);
        tid = 8'($urandom);
        tdest = 4'($urandom);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        len = 16'($urandom_range(1, 40));
        num = 16'($urandom_range(1, 3));
        tid = 8'($urandom);
        if (stray) begin
            repeat (2) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        len = '0;
        num = '0;
        tid = '0;
        tdest = '0;
        for (int d = 0; d < 2; d++) begin
            act[d] = 1'b0; dexp[d] = 1'b0; ingap[d] = 1'b0; gapcnt[d] = 0;
        end
        gen(2, 6, 2, 8'h0, 4'h0);
        chk("model_b0", {q[2][0].data, q[2][0].keep, q[2][0].last},
            {32'h03020100, 4'hF, 1'b0});
        chk("model_b1", {q[2][1].data, q[2][1].keep, q[2][1].last},
            {32'h00000504, 4'h3, 1'b1});
        chk("model_b2", {q[2][2].data, q[2][2].keep, q[2][2].last},
            {32'h04030201, 4'hF, 1'b0});
        chk("model_b3", {q[2][3].data, q[2][3].keep, q[2][3].last},
            {32'h00000605, 4'h3, 1'b1});
        q[2].delete();
        gen(2, 8, 1, 8'h0, 4'h0);
        chk("model_len8", {q[2][0].data, q[2][1].data, q[2][1].last},
            {32'h03020100, 32'h07060504, 1'b1});
        q[2].delete();

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        rmode = 0;
        run(8, 1, 1'b0);
        run(6, 2, 1'b0);
        rmode = 2;
        run(12, 1, 1'b0);
        rmode = 0;
        run(0, 3, 1'b0);
        run(5, 0, 1'b0);

        @(posedge clk);
        #1;
        len = 16'd16; num = 16'd1; tid = 8'h5A; tdest = 4'h3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run(16, 1, 1'b0);

        rmode = 1;
        run(300, 2, 1'b0);
        run(7, 3, 1'b1);
        for (int i = 0; i < 15; i++)
            run($urandom_range(0, 40), $urandom_range(0, 4), 1'($urandom));
        rmode = 2;
        run(13, 2, 1'b0);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
